// File: rtl/hdr_tx_pkg.sv
// Shared types and constants for the header-RAM frame transmit sequencer.
// Optional FCS stage is present when HDR_TX_FCS_EN is defined.
package hdr_tx_pkg;

`ifdef HDR_TX_FCS_EN
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRE,
    ST_SFD,
    ST_HDR,
    ST_PAD,
    ST_FCS,
    ST_IFG
  } state_e;
`else
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRE,
    ST_SFD,
    ST_HDR,
    ST_PAD,
    ST_IFG
  } state_e;
`endif

  localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0]  SFD_BYTE      = 8'hD5;
  localparam logic [31:0] CRC_POLY      = 32'hEDB88320;
  localparam logic [31:0] CRC_INIT      = 32'hFFFFFFFF;

  localparam int DEF_HDR_LEN      = 50;
  localparam int DEF_MIN_FRAME    = 60;
  localparam int DEF_PREAMBLE_LEN = 7;
  localparam int DEF_IFG_CYCLES   = 12;
  localparam int FCS_LEN          = 4;

endpackage

// File: rtl/hdr_tx_sequencer_crc32_d8.sv
// Byte-wise reflected CRC-32 next-state (poly 0xEDB88320, LSB first).
// Ports: crc_in (current CRC), data (byte), crc_out (CRC after byte).
import hdr_tx_pkg::*;

module crc32_d8 (
  input  logic [31:0] crc_in,
  input  logic [7:0]  data,
  output logic [31:0] crc_out
);

  logic [31:0] c;

  always_comb begin
    c = crc_in ^ {24'h0, data};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
    end
  end

  assign crc_out = c;

endmodule

// File: rtl/hdr_tx_sequencer.sv
// Frame TX sequencer: preamble, SFD, 50 header-RAM bytes, zero pad, IFG.
// Ports: start/payload_in in, payload_hold + ram_addr/ram_rd_en to RAM,
// ram_data from RAM, tx_en/tx_data byte stream, busy/done/start_ignored
// status, frame_cnt. Define HDR_TX_FCS_EN to append a CRC-32 FCS.
import hdr_tx_pkg::*;

module hdr_tx_sequencer #(
  parameter int HDR_LEN      = DEF_HDR_LEN,
  parameter int MIN_FRAME    = DEF_MIN_FRAME,
  parameter int PREAMBLE_LEN = DEF_PREAMBLE_LEN,
  parameter int IFG_CYCLES   = DEF_IFG_CYCLES
) (
  input  logic        rd_clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [63:0] payload_in,
  output logic [63:0] payload_hold,
  output logic [7:0]  ram_addr,
  output logic        ram_rd_en,
  input  logic [7:0]  ram_data,
  output logic        tx_en,
  output logic [7:0]  tx_data,
  output logic        busy,
  output logic        done,
  output logic        start_ignored,
  output logic [15:0] frame_cnt
);

  localparam int PAD_LEN =
    (MIN_FRAME > HDR_LEN) ? (MIN_FRAME - HDR_LEN) : 0;

  localparam logic [7:0] PRE_LAST = 8'(PREAMBLE_LEN - 1);
  localparam logic [7:0] HDR_LAST = 8'(HDR_LEN - 1);
  localparam logic [7:0] HDR_N    = 8'(HDR_LEN);
  localparam logic [7:0] PAD_LAST = 8'(PAD_LEN - 1);
  localparam logic [7:0] IFG_LAST = 8'(IFG_CYCLES - 1);

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        tx_en_q, tx_en_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic [63:0] payload_hold_q, payload_hold_d;
  logic [7:0]  ram_addr_q, ram_addr_d;
  logic        ram_rd_en_q, ram_rd_en_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        start_ignored_q, start_ignored_d;
  logic [15:0] frame_cnt_q, frame_cnt_d;
  logic        to_tail;
  logic        to_ifg;

`ifdef HDR_TX_FCS_EN
  localparam logic [7:0] FCS_LAST = 8'(FCS_LEN - 1);

  logic [31:0] crc_q, crc_d;
  logic [31:0] crc_nxt;
  logic [31:0] fcs;

  assign fcs = ~crc_q;

  // CRC folds in each header/pad byte as it is loaded into tx_data.
  crc32_d8 u_crc (
    .crc_in  (crc_q),
    .data    (tx_data_d),
    .crc_out (crc_nxt)
  );

  always_comb begin
    crc_d = crc_q;
    if (state_d == ST_PRE) begin
      crc_d = CRC_INIT;
    end else if (tx_en_d &&
                 (state_d == ST_HDR || state_d == ST_PAD)) begin
      crc_d = crc_nxt;
    end
  end
`endif

  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    tx_en_d         = 1'b0;
    tx_data_d       = 8'h00;
    payload_hold_d  = payload_hold_q;
    ram_addr_d      = 8'h00;
    ram_rd_en_d     = 1'b0;
    busy_d          = busy_q;
    done_d          = 1'b0;
    start_ignored_d = start && (state_q != ST_IDLE);
    frame_cnt_d     = frame_cnt_q;
    to_tail         = 1'b0;
    to_ifg          = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d        = ST_PRE;
          cnt_d          = 8'h00;
          tx_en_d        = 1'b1;
          tx_data_d      = PREAMBLE_BYTE;
          busy_d         = 1'b1;
          payload_hold_d = payload_in;
        end
      end
      ST_PRE: begin
        tx_en_d = 1'b1;
        if (cnt_q == PRE_LAST) begin
          state_d     = ST_SFD;
          cnt_d       = 8'h00;
          tx_data_d   = SFD_BYTE;
          ram_rd_en_d = 1'b1;
        end else begin
          cnt_d     = cnt_q + 8'd1;
          tx_data_d = PREAMBLE_BYTE;
        end
      end
      // Address runs one byte ahead of tx_data.
      ST_SFD: begin
        state_d   = ST_HDR;
        cnt_d     = 8'h00;
        tx_en_d   = 1'b1;
        tx_data_d = ram_data;
        if (HDR_LEN > 1) begin
          ram_rd_en_d = 1'b1;
          ram_addr_d  = 8'd1;
        end
      end
      ST_HDR: begin
        if (cnt_q == HDR_LAST) begin
          if (PAD_LEN > 0) begin
            state_d   = ST_PAD;
            cnt_d     = 8'h00;
            tx_en_d   = 1'b1;
            tx_data_d = 8'h00;
          end else begin
            to_tail = 1'b1;
          end
        end else begin
          cnt_d     = cnt_q + 8'd1;
          tx_en_d   = 1'b1;
          tx_data_d = ram_data;
          if ((cnt_q + 8'd2) < HDR_N) begin
            ram_rd_en_d = 1'b1;
            ram_addr_d  = cnt_q + 8'd2;
          end
        end
      end
      ST_PAD: begin
        if (cnt_q == PAD_LAST) begin
          to_tail = 1'b1;
        end else begin
          cnt_d     = cnt_q + 8'd1;
          tx_en_d   = 1'b1;
          tx_data_d = 8'h00;
        end
      end
`ifdef HDR_TX_FCS_EN
      ST_FCS: begin
        if (cnt_q == FCS_LAST) begin
          to_ifg = 1'b1;
        end else begin
          cnt_d     = cnt_q + 8'd1;
          tx_en_d   = 1'b1;
          tx_data_d = 8'(fcs >> {cnt_q + 8'd1, 3'b000});
        end
      end
`endif
      ST_IFG: begin
        if (cnt_q == IFG_LAST) begin
          state_d = ST_IDLE;
          cnt_d   = 8'h00;
          busy_d  = 1'b0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 8'h00;
        busy_d  = 1'b0;
      end
    endcase

    if (to_tail) begin
`ifdef HDR_TX_FCS_EN
      state_d   = ST_FCS;
      cnt_d     = 8'h00;
      tx_en_d   = 1'b1;
      tx_data_d = fcs[7:0];
`else
      to_ifg = 1'b1;
`endif
    end

    if (to_ifg) begin
      state_d     = ST_IFG;
      cnt_d       = 8'h00;
      done_d      = 1'b1;
      frame_cnt_d = frame_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge rd_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= ST_IDLE;
      cnt_q           <= 8'h00;
      tx_en_q         <= 1'b0;
      tx_data_q       <= 8'h00;
      payload_hold_q  <= 64'h0;
      ram_addr_q      <= 8'h00;
      ram_rd_en_q     <= 1'b0;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
      start_ignored_q <= 1'b0;
      frame_cnt_q     <= 16'h0;
`ifdef HDR_TX_FCS_EN
      crc_q           <= CRC_INIT;
`endif
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      tx_en_q         <= tx_en_d;
      tx_data_q       <= tx_data_d;
      payload_hold_q  <= payload_hold_d;
      ram_addr_q      <= ram_addr_d;
      ram_rd_en_q     <= ram_rd_en_d;
      busy_q          <= busy_d;
      done_q          <= done_d;
      start_ignored_q <= start_ignored_d;
      frame_cnt_q     <= frame_cnt_d;
`ifdef HDR_TX_FCS_EN
      crc_q           <= crc_d;
`endif
    end
  end

  assign tx_en         = tx_en_q;
  assign tx_data       = tx_data_q;
  assign payload_hold  = payload_hold_q;
  assign ram_addr      = ram_addr_q;
  assign ram_rd_en     = ram_rd_en_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign start_ignored = start_ignored_q;
  assign frame_cnt     = frame_cnt_q;

endmodule

// File: tb/tb_hdr_tx_sequencer.sv
// Self-checking bench for hdr_tx_sequencer with a header RAM model
// and a frame-level reference built from the frame layout rules.
module tb_hdr_tx_sequencer;

`ifdef HDR_TX_FCS_EN
  localparam int FL = 72;
`else
  localparam int FL = 68;
`endif
  localparam int NS = 256;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [63:0] payload_in;
  logic [63:0] payload_hold;
  logic [7:0]  ram_addr;
  logic        ram_rd_en;
  logic [7:0]  ram_data;
  logic        tx_en;
  logic [7:0]  tx_data;
  logic        busy;
  logic        done;
  logic        start_ignored;
  logic [15:0] frame_cnt;

  int checks = 0;
  int failures = 0;

  logic [7:0] hdr_mem [0:41];
  logic [7:0] pre14 [0:13];
  logic [7:0] exp_b [0:79];

  logic        s_en   [0:NS-1];
  logic [7:0]  s_dat  [0:NS-1];
  logic        s_done [0:NS-1];
  logic        s_busy [0:NS-1];
  logic        s_rd   [0:NS-1];
  logic [7:0]  s_addr [0:NS-1];
  logic        s_ign  [0:NS-1];
  logic [15:0] s_fc   [0:NS-1];

  hdr_tx_sequencer dut (
    .rd_clk        (clk),
    .rst_n         (rst_n),
    .start         (start),
    .payload_in    (payload_in),
    .payload_hold  (payload_hold),
    .ram_addr      (ram_addr),
    .ram_rd_en     (ram_rd_en),
    .ram_data      (ram_data),
    .tx_en         (tx_en),
    .tx_data       (tx_data),
    .busy          (busy),
    .done          (done),
    .start_ignored (start_ignored),
    .frame_cnt     (frame_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Header RAM: bytes 0-41 stored, 42-49 are the latched payload.
  always_comb begin
    int a;
    a = int'(ram_addr);
    ram_data = 8'hEE;
    if (ram_rd_en) begin
      if (a < 42) ram_data = hdr_mem[a];
      else if (a < 50) ram_data = payload_hold[8*(49-a) +: 8];
    end
  end

  task automatic build_exp(input logic [63:0] p);
    for (int i = 0; i < 7; i++) exp_b[i] = 8'h55;
    exp_b[7] = 8'hD5;
    for (int i = 0; i < 42; i++) exp_b[8+i] = hdr_mem[i];
    for (int i = 0; i < 8; i++) exp_b[50+i] = p[63-8*i -: 8];
    for (int i = 0; i < 10; i++) exp_b[58+i] = 8'h00;
`ifdef HDR_TX_FCS_EN
    begin
      logic [31:0] c;
      logic [31:0] f;
      c = 32'hFFFFFFFF;
      for (int i = 8; i < 68; i++) begin
        c = c ^ {24'h0, exp_b[i]};
        for (int b = 0; b < 8; b++)
          c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
      end
      f = ~c;
      for (int i = 0; i < 4; i++) exp_b[68+i] = f[8*i +: 8];
    end
`endif
  endtask

  task automatic kick(input logic [63:0] p);
    @(negedge clk);
    start = 1'b1;
    payload_in = p;
  endtask

  task automatic collect(input int n, input int ign_cyc, input bit hold);
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      s_en[k] = tx_en;
      s_dat[k] = tx_data;
      s_done[k] = done;
      s_busy[k] = busy;
      s_rd[k] = ram_rd_en;
      s_addr[k] = ram_addr;
      s_ign[k] = start_ignored;
      s_fc[k] = frame_cnt;
      if (!hold) start = 1'b0;
      if (ign_cyc != 0 && k == ign_cyc - 1) begin
        start = 1'b1;
        payload_in = '1;
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    start = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0;
    payload_in = '0;
    repeat (3) @(negedge clk);
    checks++;
    if ({tx_en, tx_data, busy, done, start_ignored, ram_rd_en} !== 12'h0) begin
      failures++;
      $display("FAIL rst_ctl got=%b%h%b%b%b%b exp=0", tx_en, tx_data,
               busy, done, start_ignored, ram_rd_en);
    end
    checks++;
    if (payload_hold !== 64'h0 || ram_addr !== 8'h0 || frame_cnt !== 16'h0) begin
      failures++;
      $display("FAIL rst_regs got=%h/%h/%h exp=0", payload_hold, ram_addr, frame_cnt);
    end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (tx_en !== 1'b0 || busy !== 1'b0 || frame_cnt !== 16'h0 || ram_rd_en !== 1'b0) begin
      failures++;
      $display("FAIL rst_release got=%b%b%h%b exp=0", tx_en, busy, frame_cnt, ram_rd_en);
    end
  endtask

  task automatic test_single();
    logic [63:0] p;
    p = 64'h0102030405060708;
    build_exp(p);
    kick(p);
    collect(FL + 14, 0, 0);
    for (int k = 1; k <= FL; k++) begin
      checks++;
      if (s_en[k] !== 1'b1 || s_dat[k] !== exp_b[k-1]) begin
        failures++;
        $display("FAIL single_byte c=%0d got=%b/%h exp=1/%h", k, s_en[k], s_dat[k], exp_b[k-1]);
      end
    end
    for (int i = 0; i < 14; i++) begin
      checks++;
      if (s_dat[9+i] !== pre14[i]) begin
        failures++;
        $display("FAIL hdr_prefix i=%0d got=%h exp=%h", i, s_dat[9+i], pre14[i]);
      end
    end
    for (int k = 1; k <= FL; k++) begin
      logic er;
      logic [7:0] ea;
      er = (k >= 8 && k <= 57);
      ea = er ? 8'(k - 8) : 8'h00;
      checks++;
      if (s_rd[k] !== er || s_addr[k] !== ea) begin
        failures++;
        $display("FAIL ram_win c=%0d got=%b/%h exp=%b/%h", k, s_rd[k], s_addr[k], er, ea);
      end
    end
    for (int k = FL + 1; k <= FL + 13; k++) begin
      checks++;
      if (s_en[k] !== 1'b0 || s_dat[k] !== 8'h00) begin
        failures++;
        $display("FAIL ifg_idle c=%0d got=%b/%h exp=0/00", k, s_en[k], s_dat[k]);
      end
    end
    for (int k = 1; k <= FL + 14; k++) begin
      checks++;
      if (s_done[k] !== (k == FL + 1)) begin
        failures++;
        $display("FAIL done c=%0d got=%b exp=%b", k, s_done[k], k == FL + 1);
      end
      checks++;
      if (s_busy[k] !== (k <= FL + 12)) begin
        failures++;
        $display("FAIL busy c=%0d got=%b exp=%b", k, s_busy[k], k <= FL + 12);
      end
    end
    checks++;
    if (s_fc[FL] !== 16'd0 || s_fc[FL+1] !== 16'd1) begin
      failures++;
      $display("FAIL frame_cnt got=%0d,%0d exp=0,1", s_fc[FL], s_fc[FL+1]);
    end
    checks++;
    if (payload_hold !== p) begin
      failures++;
      $display("FAIL hold got=%h exp=%h", payload_hold, p);
    end
  endtask

  task automatic test_ignored();
    logic [63:0] p;
    p = 64'h0102030405060708;
    build_exp(p);
    kick(p);
    collect(FL + 14, 30, 0);
    for (int k = 1; k <= FL; k++) begin
      checks++;
      if (s_en[k] !== 1'b1 || s_dat[k] !== exp_b[k-1]) begin
        failures++;
        $display("FAIL ign_byte c=%0d got=%b/%h exp=1/%h", k, s_en[k], s_dat[k], exp_b[k-1]);
      end
    end
    for (int k = 1; k <= FL + 14; k++) begin
      checks++;
      if (s_ign[k] !== (k == 30)) begin
        failures++;
        $display("FAIL start_ign c=%0d got=%b exp=%b", k, s_ign[k], k == 30);
      end
    end
    checks++;
    if (payload_hold !== p) begin
      failures++;
      $display("FAIL ign_hold got=%h exp=%h", payload_hold, p);
    end
    checks++;
    if (s_fc[FL+1] !== 16'd2) begin
      failures++;
      $display("FAIL ign_cnt got=%0d exp=2", s_fc[FL+1]);
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] p;
    int lows;
    int k;
    bit idle;
    do_reset();
    p = {$urandom, $urandom};
    build_exp(p);
    kick(p);
    collect(2 * FL + 15, 0, 1);
    start = 1'b0;
    for (int j = 1; j <= FL; j++) begin
      checks++;
      if (s_dat[j] !== exp_b[j-1] || s_dat[FL+13+j] !== exp_b[j-1]) begin
        failures++;
        $display("FAIL b2b_byte j=%0d got=%h,%h exp=%h", j, s_dat[j], s_dat[FL+13+j], exp_b[j-1]);
      end
    end
    lows = 0;
    k = FL + 1;
    while (k < NS && s_en[k] === 1'b0) begin
      lows++;
      k++;
    end
    checks++;
    if (lows !== 13) begin
      failures++;
      $display("FAIL b2b_gap got=%0d exp=13", lows);
    end
    checks++;
    if (s_fc[FL+1] !== 16'd1 || s_fc[2*FL+13] !== 16'd1 || s_fc[2*FL+14] !== 16'd2) begin
      failures++;
      $display("FAIL b2b_cnt got=%0d,%0d,%0d exp=1,1,2",
               s_fc[FL+1], s_fc[2*FL+13], s_fc[2*FL+14]);
    end
    checks++;
    if (s_done[2*FL+14] !== 1'b1) begin
      failures++;
      $display("FAIL b2b_done got=%b exp=1", s_done[2*FL+14]);
    end
    idle = 0;
    for (int i = 0; i < 40 && !idle; i++) begin
      @(negedge clk);
      if (busy === 1'b0) idle = 1;
    end
    checks++;
    if (!idle) begin
      failures++;
      $display("FAIL b2b_idle got=busy exp=idle within 40 cycles");
    end
  endtask

  task automatic test_mid_reset();
    logic [63:0] p;
    int n;
    p = {$urandom, $urandom};
    build_exp(p);
    kick(p);
    collect(20, 0, 0);
    rst_n = 1'b0;
    #1;
    checks++;
    if (tx_en !== 1'b0 || tx_data !== 8'h00 || busy !== 1'b0) begin
      failures++;
      $display("FAIL mid_rst_tx got=%b/%h/%b exp=0", tx_en, tx_data, busy);
    end
    checks++;
    if (payload_hold !== 64'h0 || ram_addr !== 8'h0 || ram_rd_en !== 1'b0 ||
        frame_cnt !== 16'h0) begin
      failures++;
      $display("FAIL mid_rst_regs got=%h/%h/%b/%h exp=0",
               payload_hold, ram_addr, ram_rd_en, frame_cnt);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    p = {$urandom, $urandom};
    build_exp(p);
    kick(p);
    collect(FL + 14, 0, 0);
    n = 0;
    for (int k = 1; k <= FL + 14; k++) begin
      if (s_en[k] === 1'b1) n++;
      if (k <= FL) begin
        checks++;
        if (s_dat[k] !== exp_b[k-1]) begin
          failures++;
          $display("FAIL post_rst_byte c=%0d got=%h exp=%h", k, s_dat[k], exp_b[k-1]);
        end
      end
    end
    checks++;
    if (n !== FL) begin
      failures++;
      $display("FAIL post_rst_len got=%0d exp=%0d", n, FL);
    end
    checks++;
    if (s_fc[FL+1] !== 16'd1 || s_done[FL+1] !== 1'b1) begin
      failures++;
      $display("FAIL post_rst_cnt got=%0d/%b exp=1/1", s_fc[FL+1], s_done[FL+1]);
    end
  endtask

  initial begin
    pre14 = '{8'h00, 8'h1C, 8'hC0, 8'h98, 8'h6D, 8'h10, 8'h00,
              8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h08, 8'h00};
    for (int i = 0; i < 14; i++) hdr_mem[i] = pre14[i];
    for (int i = 14; i < 42; i++) hdr_mem[i] = 8'($urandom);
    test_reset();
    test_single();
    test_ignored();
    test_back_to_back();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hdr_tx_sequencer.md
# hdr_tx_sequencer

Frame transmit sequencer for the 50-byte header RAM (Ethernet/IPv4/UDP header in bytes 0–41, 8-byte payload in 42–49). On a `start` pulse it latches the 8-byte payload into the RAM's payload inputs, then emits a byte-wide GMII-style frame: preamble, SFD, RAM bytes 0–49 in address order, zero padding to the 60-byte minimum, optional FCS, then an inter-frame gap. It sits between the sample source and the MAC/PHY byte interface and is the only master driving the header RAM address and read-enable.

## Interface
- `HDR_LEN`, 50: header RAM bytes transmitted per frame.
- `MIN_FRAME`, 60: minimum frame bytes before FCS; zero-pad up to this.
- `PREAMBLE_LEN`, 7: count of 0x55 bytes before the SFD.
- `IFG_CYCLES`, 12: idle cycles after the last byte.
- `rd_clk  in  1  single clock, all logic rising-edge.`
- `rst_n  in  1  asynchronous active-low reset.`
- `start  in  1  request one frame; sampled only in IDLE.`
- `payload_in  in  64  payload sample; [63:56] maps to RAM byte 42, [7:0] to byte 49.`
- `payload_hold  out  64  latched payload driving RAM data_in1..8 (data_in1=[63:56]).`
- `ram_addr  out  8  header RAM address.`
- `ram_rd_en  out  1  header RAM read enable.`
- `ram_data  in  8  header RAM output, combinational on ram_addr.`
- `tx_en  out  1  frame byte valid.`
- `tx_data  out  8  frame byte.`
- `busy  out  1  high from the first preamble cycle to the end of IFG.`
- `done  out  1  one-cycle pulse in the first cycle after the last frame byte.`
- `start_ignored  out  1  one-cycle pulse when `start` arrives while not IDLE.`
- `frame_cnt  out  16  completed frames; wraps 0xFFFF→0x0000.`

## Operation
- States: IDLE → PREAMBLE → SFD → HDR → PAD → FCS (macro only) → IFG → IDLE.
- IDLE with `start`=1: load `payload_hold` ← `payload_in` and enter PREAMBLE. `payload_hold` stays stable until the next accepted start.
- PREAMBLE: emit `PREAMBLE_LEN` bytes of 0x55. SFD: emit 0xD5.
- HDR: emit RAM bytes 0..`HDR_LEN`-1. `ram_addr` and the RAM read run one cycle ahead of `tx_data`; `tx_data` is registered from `ram_data`.
- PAD: emit `MIN_FRAME`-`HDR_LEN` bytes of 0x00. Skip PAD when `HDR_LEN` ≥ `MIN_FRAME`.
- IFG: hold `tx_en`=0 for `IFG_CYCLES` cycles, then go to IDLE.
- `start` outside IDLE: ignored, `start_ignored` pulses, no queuing, and `payload_hold` is untouched.
- `done` and the `frame_cnt` increment happen at the same edge: the first IFG cycle.
- Reset, including mid-frame: all outputs go to 0 immediately (`tx_en`, `tx_data`, `payload_hold`, `ram_addr`, `ram_rd_en`, `busy`, `done`, `start_ignored`, `frame_cnt`) and the state returns to IDLE. No partial frame resumes.
- `tx_data` = 0x00 whenever `tx_en`=0. `ram_addr` = 0 outside its fetch window.

## Timing
- Start is sampled at edge E0; cycle k means the cycle following edge Ek.
- Cycles 1–7: preamble, `tx_en`=1, `busy`=1.
- Cycle 8: SFD; `ram_rd_en`=1, `ram_addr`=0.
- `ram_rd_en`=1 for cycles 8–57, with `ram_addr`=n in cycle 8+n. Header byte n appears on `tx_data` in cycle 9+n (cycles 9–58).
- Cycles 59–68: pad. Cycles 69–72: FCS (macro only).
- With FCS: `tx_en` high for cycles 1–72. `done` in cycle 73, IFG in cycles 73–84, IDLE in cycle 85.
- With `start` held high, the next frame's `tx_en` rises in cycle 86, giving `IFG_CYCLES`+1 = 13 low cycles between frames.
- Without FCS: `tx_en` high for cycles 1–68, `done` in cycle 69, IDLE in cycle 81.
- Latency from `start` to the first byte: 1 cycle.

## Configuration
- `HDR_TX_FCS_EN` defined: append IEEE 802.3 CRC-32 over all header and pad bytes. Reflected polynomial 0xEDB88320, init 0xFFFFFFFF, final XOR 0xFFFFFFFF, least-significant byte first, 4 bytes.
- `HDR_TX_FCS_EN` undefined: no FCS state and no CRC logic; the frame ends after PAD.

## Structure
- `hdr_tx_pkg` holds: the state enum, PREAMBLE_BYTE=0x55, SFD_BYTE=0xD5, CRC_POLY=0xEDB88320, CRC_INIT=0xFFFFFFFF, and default `MIN_FRAME`/`IFG_CYCLES`.
- Sub-module `crc32_d8`: combinational byte-wise CRC next-state. It is instantiated only under `HDR_TX_FCS_EN`.

## Test plan
- Reset: hold `rst_n`=0 → every output is 0. Release with `start`=0 → outputs stay 0 and `busy`=0.
- Single frame, `payload_in`=0x0102030405060708 → expected stream:
  - 7×0x55, then 0xD5.
  - Header bytes begin 00 1C C0 98 6D 10 00 11 22 33 44 55 08 00.
  - Bytes 42–49 are 01..08, followed by 10×0x00.
  - FCS matches the software CRC model.
  - `done` in cycle 73 and `frame_cnt`=1.
- `start` pulsed in cycle 30 with `payload_in`=0xFF..FF → `start_ignored` pulses, frame bytes are unchanged, and `payload_hold` stays 0x0102030405060708.
- `start` held high for two frames → exactly 13 `tx_en`-low cycles between frames, and `frame_cnt` reads 1 then 2.
- `rst_n` pulsed low in cycle 20 → `tx_en` drops asynchronously. The next start yields a complete, correct 72-byte frame and `frame_cnt`=1.
- `HDR_TX_FCS_EN` undefined → `tx_en` high for exactly 68 cycles, last byte 0x00, `done` in cycle 69.
